snoop_bus_ctrl: RTL
===================

# snoop_bus_ctrl

- Bus-side responder at the far end of a cache's `sdreq`/`sursp` and `sureq`/`sdrsp` channels.
- Accepts one miss, upgrade or writeback request at a time from the requesting cache.
- Snoops the peer cache, then sources the block either from the peer or from a memory port.
- Returns a single `sursp` response to the requester, telling it where the data came from.

## Interface
- `PADDR_WIDTH`, 64, physical address width
- `BLK_WIDTH`, 512, block width in bits
- `SADDR_WIDTH`, `PADDR_WIDTH-$clog2(BLK_WIDTH/8)`, block address width
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sdreq_valid/op/addr/data` in 1/3/SADDR_WIDTH/BLK_WIDTH: request from the requesting cache.
- `sdreq_ready` out 1: request accepted.
- `sursp_valid/rsp/data` out 1/3/BLK_WIDTH: response to the requester.
- `sursp_ready` in 1: requester accepts the response.
- `sureq_valid/op/addr` out 1/2/SADDR_WIDTH: snoop to the peer cache.
- `sureq_ready` in 1: peer accepts the snoop.
- `sdrsp_valid/rsp/data` in 1/2/BLK_WIDTH: peer snoop response.
- `sdrsp_ready` out 1: snoop response accepted.
- `mem_req_valid/we/addr/data` out 1/1/SADDR_WIDTH/BLK_WIDTH: memory request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_rsp_valid/data` in 1/BLK_WIDTH: memory read data.
- `mem_rsp_ready` out 1: read data accepted.

## Operation
- Request ops:
  - `SDREQ_RD`=0, `SDREQ_RFO`=1, `SDREQ_INV`=2, `SDREQ_WB`=3; other values are treated as `SDREQ_RD`.
- Snoop ops:
  - `SNP_RD`=0 for `SDREQ_RD`.
  - `SNP_RFO`=1 for `SDREQ_RFO`.
  - `SNP_INV`=2 for `SDREQ_INV`.
- Peer responses:
  - `SDRSP_MISS`=0: peer has no copy.
  - `SDRSP_CLEAN`=1: peer returns clean data.
  - `SDRSP_DIRTY`=2: peer returns dirty data.
- Requester responses:
  - `SURSP_OKAY`=0: no data returned.
  - `SURSP_FETCH`=1: data sourced from memory.
  - `SURSP_SNOOP`=2: data sourced from the peer.
- FSM states and transitions:
  - IDLE: `sdreq_ready`=1. On `sdreq_valid`, latch op/addr/data. Go to MEM_WR for WB, otherwise SNOOP.
  - SNOOP: `sureq_valid`=1, holding the latched address. On `sureq_ready`, go to WAIT_SNP.
  - WAIT_SNP: `sdrsp_ready`=1. On `sdrsp_valid`:
    - CLEAN or DIRTY, and op is RD or RFO: latch the data with `SURSP_SNOOP`, go to RESP (or MEM_WB, see Configuration).
    - Op is INV: `SURSP_OKAY`, go to RESP.
    - MISS with RD or RFO: go to MEM_RD.
  - MEM_RD: `mem_req_valid`=1, `we`=0. On `mem_req_ready`, go to MEM_WAIT.
  - MEM_WAIT: `mem_rsp_ready`=1. On `mem_rsp_valid`, latch the data with `SURSP_FETCH`, go to RESP.
  - MEM_WR: `mem_req_valid`=1, `we`=1, data = latched `sdreq_data`. On `mem_req_ready`, `SURSP_OKAY`, go to RESP.
  - RESP: `sursp_valid`=1. On `sursp_ready`, go to IDLE.
- All `*_valid` and `*_ready` outputs are decoded from the registered state only, never combinationally from inputs.
- Payload outputs (op, addr, data, rsp) come from registers and stay stable while the corresponding valid is high.
- `sursp_data` is zero when the response is `SURSP_OKAY`.
- Blocking: a new `sdreq` is never accepted outside IDLE.
- Inputs outside their wait state are ignored, including a stray `sdrsp_valid` or `mem_rsp_valid`.

## Timing
- Reset values:
  - Every valid and ready output is 0, including `sdreq_ready`, which rises the first cycle after `rst` deasserts.
  - All payload registers are 0. State is IDLE.
- Best case, peer hit, with all readies and valids immediate:
  - Request accepted at cycle 0.
  - `sureq_valid` at cycle 1.
  - `sdrsp` accepted at cycle 2.
  - `sursp_valid` at cycle 3.
- Peer miss: `sursp_valid` no earlier than cycle 5.
- `rst` mid-transaction drops the transaction. All outputs are 0 on the next edge and nothing is replayed.
- Valid held with ready low: the state and payload are held indefinitely.

## Configuration
- `SNOOP_BUS_DIRTY_WB_EN`
  - Defined: an `SDRSP_DIRTY` response with RD enters MEM_WB before RESP. MEM_WB drives `mem_req_valid`=1, `we`=1, data = peer data, and leaves on `mem_req_ready`. RFO responses are not written back.
  - Undefined: MEM_WB does not exist and DIRTY is handled exactly like CLEAN.

## Structure
- Shared `cache_pkg` holds:
  - The SDREQ, SNP, SDRSP and SURSP constants above.
  - The bus FSM state enum (`BUS_IDLE`…`BUS_RESP`).
- Sub-module `snoop_bus_fsm`: purely combinational next-state and output decode.
- The top level holds the state and payload registers.

## Test plan
- `SDREQ_RD` addr 0x1A, peer `SDRSP_CLEAN` with data 0xAA…: `sureq_op`=0 and addr 0x1A; `sursp_rsp`=2, data 0xAA…; no memory request.
- `SDREQ_RFO` addr 0x20, peer MISS, memory returns 0x55…: `mem_req` with `we`=0 and addr 0x20; `sursp_rsp`=1, data 0x55….
- `SDREQ_WB` addr 0x7, data 0x33…: no snoop issued; `mem_req` with `we`=1 and data 0x33…; `sursp_rsp`=0.
- `SDREQ_RD` with peer DIRTY under the macro: a memory write of the peer data precedes `sursp_rsp`=2. Without the macro, no memory write occurs.
- Backpressure: `sureq_ready`, `mem_req_ready` and `sursp_ready` held low for 5 cycles each. Payloads stay stable; the transaction completes once readies rise; a second `sdreq` is not accepted meanwhile.
- `rst` pulsed during MEM_WAIT: all outputs are 0 on the next edge; a late `mem_rsp_valid` is ignored; `sdreq_ready`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache bus encodings and the snoop bus FSM state type.
// SNOOP_BUS_DIRTY_WB_EN adds the MEM_WB state for dirty peer data.
package cache_pkg;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd3;

  localparam logic [1:0] SNP_RD  = 2'd0;
  localparam logic [1:0] SNP_RFO = 2'd1;
  localparam logic [1:0] SNP_INV = 2'd2;

  localparam logic [1:0] SDRSP_MISS  = 2'd0;
  localparam logic [1:0] SDRSP_CLEAN = 2'd1;
  localparam logic [1:0] SDRSP_DIRTY = 2'd2;

  localparam logic [2:0] SURSP_OKAY  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SNOOP,
    BUS_WAIT_SNP,
    BUS_MEM_RD,
    BUS_MEM_WAIT,
    BUS_MEM_WR,
`ifdef SNOOP_BUS_DIRTY_WB_EN
    BUS_MEM_WB,
`endif
    BUS_RESP
  } bus_state_t;

  // Unknown request codes behave as plain reads.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > SDREQ_WB) ? SDREQ_RD : op;
  endfunction

  function automatic logic [1:0] snp_op(input logic [2:0] op);
    logic [1:0] s;
    unique case (1'b1)
      op == SDREQ_RFO: s = SNP_RFO;
      op == SDREQ_INV: s = SNP_INV;
      default:         s = SNP_RD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Request, snoop and memory channels of the snoop bus responder.
// slave is the responder side, master the cache/memory side.
interface snoop_bus_ctrl_if #(
  parameter int PADDR_WIDTH = 64,
  parameter int BLK_WIDTH   = 512,
  parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8)
);
  logic                   sdreq_valid;
  logic                   sdreq_ready;
  logic [2:0]             sdreq_op;
  logic [SADDR_WIDTH-1:0] sdreq_addr;
  logic [BLK_WIDTH-1:0]   sdreq_data;

  logic                   sursp_valid;
  logic                   sursp_ready;
  logic [2:0]             sursp_rsp;
  logic [BLK_WIDTH-1:0]   sursp_data;

  logic                   sureq_valid;
  logic                   sureq_ready;
  logic [1:0]             sureq_op;
  logic [SADDR_WIDTH-1:0] sureq_addr;

  logic                   sdrsp_valid;
  logic                   sdrsp_ready;
  logic [1:0]             sdrsp_rsp;
  logic [BLK_WIDTH-1:0]   sdrsp_data;

  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_we;
  logic [SADDR_WIDTH-1:0] mem_req_addr;
  logic [BLK_WIDTH-1:0]   mem_req_data;

  logic                   mem_rsp_valid;
  logic                   mem_rsp_ready;
  logic [BLK_WIDTH-1:0]   mem_rsp_data;

  modport slave (
    input  sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
    output sdreq_ready,
    output sursp_valid, sursp_rsp, sursp_data,
    input  sursp_ready,
    output sureq_valid, sureq_op, sureq_addr,
    input  sureq_ready,
    input  sdrsp_valid, sdrsp_rsp, sdrsp_data,
    output sdrsp_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output mem_rsp_ready
  );

  modport master (
    output sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
    input  sdreq_ready,
    input  sursp_valid, sursp_rsp, sursp_data,
    output sursp_ready,
    input  sureq_valid, sureq_op, sureq_addr,
    output sureq_ready,
    output sdrsp_valid, sdrsp_rsp, sdrsp_data,
    input  sdrsp_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/snoop_bus_fsm.sv
// Next-state and handshake decode for the snoop bus responder.
// SNOOP_BUS_DIRTY_WB_EN routes dirty peer reads through MEM_WB.
module snoop_bus_fsm
  import cache_pkg::*;
(
  input  bus_state_t state_i,
  input  logic       live_i,
  input  logic [2:0] op_i,
  input  logic       sdreq_valid_i,
  input  logic [2:0] sdreq_op_i,
  input  logic       sureq_ready_i,
  input  logic       sdrsp_valid_i,
  input  logic [1:0] sdrsp_rsp_i,
  input  logic       mem_req_ready_i,
  input  logic       mem_rsp_valid_i,
  input  logic       sursp_ready_i,
  output bus_state_t state_d_o,
  output logic       req_take_o,
  output logic       snp_take_o,
  output logic       snp_okay_o,
  output logic       mem_take_o,
  output logic       wr_done_o,
  output logic       sdreq_ready_o,
  output logic       sureq_valid_o,
  output logic       sdrsp_ready_o,
  output logic       mem_req_valid_o,
  output logic       mem_req_we_o,
  output logic       mem_rsp_ready_o,
  output logic       sursp_valid_o
);

  logic hit;
  logic wb_st;

  assign hit = (sdrsp_rsp_i == SDRSP_CLEAN) ||
               (sdrsp_rsp_i == SDRSP_DIRTY);

`ifdef SNOOP_BUS_DIRTY_WB_EN
  assign wb_st = (state_i == BUS_MEM_WB);
`else
  assign wb_st = 1'b0;
`endif

  always_comb begin
    state_d_o  = state_i;
    req_take_o = 1'b0;
    snp_take_o = 1'b0;
    snp_okay_o = 1'b0;
    mem_take_o = 1'b0;
    wr_done_o  = 1'b0;
    unique case (state_i)
      BUS_IDLE: if (live_i && sdreq_valid_i) begin
        req_take_o = 1'b1;
        state_d_o  = (norm_op(sdreq_op_i) == SDREQ_WB) ?
                     BUS_MEM_WR : BUS_SNOOP;
      end
      BUS_SNOOP: if (sureq_ready_i) state_d_o = BUS_WAIT_SNP;
      BUS_WAIT_SNP: if (sdrsp_valid_i) begin
        if (op_i == SDREQ_INV) begin
          snp_okay_o = 1'b1;
          state_d_o  = BUS_RESP;
        end else if (!hit) begin
          state_d_o  = BUS_MEM_RD;
        end else begin
          snp_take_o = 1'b1;
          state_d_o  = BUS_RESP;
`ifdef SNOOP_BUS_DIRTY_WB_EN
          if (sdrsp_rsp_i == SDRSP_DIRTY && op_i == SDREQ_RD)
            state_d_o = BUS_MEM_WB;
`endif
        end
      end
      BUS_MEM_RD: if (mem_req_ready_i) state_d_o = BUS_MEM_WAIT;
      BUS_MEM_WAIT: if (mem_rsp_valid_i) begin
        mem_take_o = 1'b1;
        state_d_o  = BUS_RESP;
      end
      BUS_MEM_WR: if (mem_req_ready_i) begin
        wr_done_o = 1'b1;
        state_d_o = BUS_RESP;
      end
`ifdef SNOOP_BUS_DIRTY_WB_EN
      BUS_MEM_WB: if (mem_req_ready_i) state_d_o = BUS_RESP;
`endif
      BUS_RESP: if (sursp_ready_i) state_d_o = BUS_IDLE;
      default: state_d_o = BUS_IDLE;
    endcase
  end

  assign sdreq_ready_o   = live_i && (state_i == BUS_IDLE);
  assign sureq_valid_o   = (state_i == BUS_SNOOP);
  assign sdrsp_ready_o   = (state_i == BUS_WAIT_SNP);
  assign mem_req_valid_o = (state_i == BUS_MEM_RD) ||
                           (state_i == BUS_MEM_WR) || wb_st;
  assign mem_req_we_o    = (state_i == BUS_MEM_WR) || wb_st;
  assign mem_rsp_ready_o = (state_i == BUS_MEM_WAIT);
  assign sursp_valid_o   = (state_i == BUS_RESP);

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop bus responder: one request at a time, peer snoop, then memory.
// Build with SNOOP_BUS_DIRTY_WB_EN to write dirty peer reads back.
module snoop_bus_ctrl
  import cache_pkg::*;
#(
  parameter int PADDR_WIDTH = 64,
  parameter int BLK_WIDTH   = 512,
  parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8)
) (
  input logic             clk,
  input logic             rst,
  snoop_bus_ctrl_if.slave bus
);

  bus_state_t             state_q, state_d;
  logic                   live_q;
  logic [2:0]             op_q;
  logic [SADDR_WIDTH-1:0] addr_q;
  logic [BLK_WIDTH-1:0]   data_q;
  logic [2:0]             rsp_q;
  logic                   req_take, snp_take, snp_okay;
  logic                   mem_take, wr_done;

  snoop_bus_fsm u_fsm (
    .state_i         (state_q),
    .live_i          (live_q),
    .op_i            (op_q),
    .sdreq_valid_i   (bus.sdreq_valid),
    .sdreq_op_i      (bus.sdreq_op),
    .sureq_ready_i   (bus.sureq_ready),
    .sdrsp_valid_i   (bus.sdrsp_valid),
    .sdrsp_rsp_i     (bus.sdrsp_rsp),
    .mem_req_ready_i (bus.mem_req_ready),
    .mem_rsp_valid_i (bus.mem_rsp_valid),
    .sursp_ready_i   (bus.sursp_ready),
    .state_d_o       (state_d),
    .req_take_o      (req_take),
    .snp_take_o      (snp_take),
    .snp_okay_o      (snp_okay),
    .mem_take_o      (mem_take),
    .wr_done_o       (wr_done),
    .sdreq_ready_o   (bus.sdreq_ready),
    .sureq_valid_o   (bus.sureq_valid),
    .sdrsp_ready_o   (bus.sdrsp_ready),
    .mem_req_valid_o (bus.mem_req_valid),
    .mem_req_we_o    (bus.mem_req_we),
    .mem_rsp_ready_o (bus.mem_rsp_ready),
    .sursp_valid_o   (bus.sursp_valid)
  );

  // data_q doubles as write data and response data; OKAY clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      live_q  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= SURSP_OKAY;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      if (req_take) begin
        op_q   <= norm_op(bus.sdreq_op);
        addr_q <= bus.sdreq_addr;
        data_q <= (norm_op(bus.sdreq_op) == SDREQ_WB) ?
                  bus.sdreq_data : '0;
        rsp_q  <= SURSP_OKAY;
      end
      if (snp_take) begin
        data_q <= bus.sdrsp_data;
        rsp_q  <= SURSP_SNOOP;
      end
      if (snp_okay || wr_done) begin
        data_q <= '0;
        rsp_q  <= SURSP_OKAY;
      end
      if (mem_take) begin
        data_q <= bus.mem_rsp_data;
        rsp_q  <= SURSP_FETCH;
      end
    end
  end

  assign bus.sureq_op     = snp_op(op_q);
  assign bus.sureq_addr   = addr_q;
  assign bus.mem_req_addr = addr_q;
  assign bus.mem_req_data = data_q;
  assign bus.sursp_rsp    = rsp_q;
  assign bus.sursp_data   = data_q;

endmodule
